bit_deser: RTL
==============

# bit_deser

Synchronous bit-stream deserializer that consumes the 1-bit output of the `dff3` capture flop and assembles framed serial bits into parallel words. Each frame is one start bit (0), `WIDTH` data bits LSB-first, an optional parity bit, and one stop bit (1). Completed words are presented on a one-entry valid/ready output register. Framing, parity and overflow errors are reported on sticky flags.

## Interface
- `WIDTH`, default 8: data bits per frame, legal range 2..32.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `d_valid`  in  1  `d` carries a frame bit this cycle.
- `d`  in  1  serial bit, driven from the upstream flop `q`.
- `out_data`  out  WIDTH  assembled word.
- `out_valid`  out  1  `out_data` holds an unconsumed word.
- `out_ready`  in  1  downstream accepts the word when high together with `out_valid`.
- `err_clr`  in  1  clears all sticky error flags.
- `frame_err`  out  1  sticky; a stop bit was sampled as 0.
- `overflow`  out  1  sticky; a word completed while the output register was full and not being drained.
- `par_err`  out  1  sticky; parity mismatch. Tied to 0 when parity is compiled out.

## Operation
- The FSM advances only on cycles with `d_valid`=1. When `d_valid`=0 the FSM holds its state, bit counter and shift register unchanged.
- IDLE: on `d`=0, go to DATA with the counter cleared. On `d`=1, stay in IDLE (line idle).
- DATA: shift `d` into bit `cnt`, then increment `cnt`. When `cnt`==`WIDTH`-1, go to PARITY if compiled in, otherwise to STOP.
- PARITY: the expected bit is the XOR-reduction of the data bits (even parity). On mismatch, set `par_err`, drop the word, and return to IDLE.
- STOP, `d`=1: commit the word, then return to IDLE.
- STOP, `d`=0: set `frame_err`, drop the word, and return to IDLE. The stop bit is not reinterpreted as a start bit.
- Commit rules:
  - If `out_valid`=0, or `out_valid`&&`out_ready` in the same cycle, load `out_data` and set `out_valid`=1.
  - Otherwise set `overflow`, drop the new word, and keep the old word unchanged.
- Output handshake:
  - `out_valid` falls on `out_valid`&&`out_ready` unless a commit happens in the same cycle.
  - `out_data` is stable while `out_valid`=1 and no transfer occurs.
- Sticky flags:
  - `err_clr` clears all sticky flags.
  - If `err_clr` and a new error event occur in the same cycle, set wins.
- Counter is `$clog2(WIDTH)` bits wide. It never wraps past `WIDTH`-1 because the state change happens on the last data bit.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `frame_err`=0, `overflow`=0, `par_err`=0, FSM=IDLE, `cnt`=0, shift register=0.
- Reset asserted mid-frame abandons the partial frame; no flag is set.
- Latency: `out_valid` rises on the clock edge following the edge that samples a good stop bit.
- Error flags rise on the edge following the edge that samples the offending bit.
- Minimum frame length is `WIDTH`+2 valid cycles, or `WIDTH`+3 with parity. Back-to-back frames need no idle bits.
- `out_ready` has no combinational path to any output.

## Configuration
- `BIT_DESER_PARITY_EN` defined: the PARITY state exists and `par_err` is live. A frame is `WIDTH`+3 bits.
- `BIT_DESER_PARITY_EN` undefined: no PARITY state, and DATA goes directly to STOP. `par_err` is constant 0. A frame is `WIDTH`+2 bits.

## Structure
- `bit_deser_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t`;
  - the frame bit constants `START_BIT`=1'b0 and `STOP_BIT`=1'b1.
- Sub-module `bit_shreg` is a `WIDTH`-bit indexed-load register with clear and load-enable. `bit_deser` instantiates it once.
- Top level holds the FSM, counter, output register and flags.

## Test plan
All scenarios use `WIDTH`=8.
- Reset low for 3 cycles with random `d`/`d_valid` → all outputs 0, FSM in IDLE after release.
- Frame 0, bits of 8'hA5 LSB-first, 1, with `out_ready`=1 → `out_data`=8'hA5, `out_valid` high for exactly one cycle, one edge after the stop bit.
- Same frame with `d_valid` gapped every other cycle → same result, 8'hA5.
- Two frames 8'h3C then 8'hC3 with `out_ready`=0 → `out_data` stays 8'h3C and `overflow`=1. Then `err_clr`=1 → `overflow`=0.
- Frame with stop bit 0 → `frame_err`=1, `out_valid` stays 0. A following good frame 8'h01 → `out_data`=8'h01.
- With the macro: data 8'h07 (three ones) and parity bit 0 → `par_err`=1 and the word is dropped. Parity bit 1 → word 8'h07 is delivered.

Source files
------------

// File: rtl/bit_deser_pkg.sv
// bit_deser_pkg: FSM state encoding and frame bit constants shared by bit_deser.
package bit_deser_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
endpackage

// File: rtl/bit_shreg.sv
// bit_shreg: WIDTH-bit register loading one bit at a time at an index, with sync clear.
module bit_shreg #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     clr_i,
  input  logic                     ld_i,
  input  logic [$clog2(WIDTH)-1:0] idx_i,
  input  logic                     bit_i,
  output logic [WIDTH-1:0]         q_o
);
  logic [WIDTH-1:0] q_q;
  always_ff @(posedge clk) begin
    if (clr_i) q_q <= '0;
    else if (ld_i) q_q[idx_i] <= bit_i;
  end
  assign q_o = q_q;
endmodule

// File: rtl/bit_deser.sv
// bit_deser: framed serial-to-parallel deserializer with valid/ready output and sticky errors.
// Define BIT_DESER_PARITY_EN to add an even-parity bit after the data bits.
module bit_deser
  import bit_deser_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_valid,
  input  logic             d,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             err_clr,
  output logic             frame_err,
  output logic             overflow,
  output logic             par_err
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifdef BIT_DESER_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] word, out_data_q, out_data_d;
  logic out_valid_q, out_valid_d, frame_err_q, frame_err_d, overflow_q, overflow_d;
  logic ld, commit, fe, load;
`ifdef BIT_DESER_PARITY_EN
  logic pe, par_err_q, par_err_d;
`endif
  bit_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk  (clk),
    .clr_i(!reset),
    .ld_i (ld),
    .idx_i(cnt_q),
    .bit_i(d),
    .q_o  (word)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ld = 1'b0;
    commit = 1'b0;
    fe = 1'b0;
`ifdef BIT_DESER_PARITY_EN
    pe = 1'b0;
`endif
    if (d_valid) begin
      case (state_q)
        IDLE: begin
          state_d = (d == START_BIT) ? DATA : IDLE;
          cnt_d = '0;
        end
        DATA: begin
          ld = 1'b1;
          state_d = (cnt_q == LAST) ? AFTER_DATA : DATA;
          cnt_d = (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
        end
`ifdef BIT_DESER_PARITY_EN
        PARITY: begin
          pe = d != ^word;
          state_d = pe ? IDLE : STOP;
        end
`endif
        STOP: begin
          commit = d == STOP_BIT;
          fe = !commit;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // a commit may reuse the slot being drained this same cycle
  assign load = commit && (!out_valid_q || out_ready);
  assign out_valid_d = load || (out_valid_q && !out_ready);
  assign out_data_d = load ? word : out_data_q;
  assign frame_err_d = fe || (frame_err_q && !err_clr);
  assign overflow_d = (commit && !load) || (overflow_q && !err_clr);
`ifdef BIT_DESER_PARITY_EN
  assign par_err_d = pe || (par_err_q && !err_clr);
  always_ff @(posedge clk) begin
    if (!reset) par_err_q <= 1'b0;
    else par_err_q <= par_err_d;
  end
  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      out_data_q <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      out_data_q <= out_data_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      overflow_q <= overflow_d;
    end
  end
  assign out_data = out_data_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign overflow = overflow_q;
endmodule
